// File: rtl/gpio_pkg.sv
// Shared constants and types for the gpio peripheral: register map,
// direction encoding and the register-select type used by the APB decode.
package gpio_pkg;

  localparam int GPIO_WIDTH  = 8;
  localparam int GPIO_ADDR_W = 8;

  localparam logic [7:0] ADDR_DATA = 8'h00;
  localparam logic [7:0] ADDR_DIR  = 8'h01;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_DATA = 2'd1,
    SEL_DIR  = 2'd2
  } reg_sel_e;

  function automatic logic drives_pad(input logic dir_bit);
    return dir_bit == DIR_OUT;
  endfunction

endpackage

// File: rtl/gpio_if.sv
// APB slave bus bundle for the gpio peripheral; the bus master drives the
// request side, the peripheral returns read data and the ready strobe.
interface gpio_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
);

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [WIDTH-1:0]  PWDATA;
  logic [WIDTH-1:0]  PRDATA;
  logic              PREADY;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );

endinterface

// File: rtl/gpio_pin_cell.sv
// One GPIO pad: tristate driver controlled by the direction bit, plus an
// unsynchronised tap of the pad level for read-back.
module gpio_pin_cell
  import gpio_pkg::*;
(
  input  logic out_i,
  input  logic dir_i,
  output logic in_o,
  inout  wire  pad
);

  assign pad  = drives_pad(dir_i) ? out_i : 1'bz;
  assign in_o = pad;

endmodule

// File: rtl/gpio.sv
// 8-bit GPIO peripheral on APB: DATA and DIRECTION registers, zero-wait-state
// access, and one pad cell per pin driving DATA wherever DIRECTION selects output.
module gpio
  import gpio_pkg::*;
#(
  parameter int WIDTH  = GPIO_WIDTH,
  parameter int ADDR_W = GPIO_ADDR_W
) (
  input  logic       PCLK,
  input  logic       PRESET,
  gpio_if.slave      apb,
  inout  wire  [WIDTH-1:0] pins
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q,  dir_d;
  logic [WIDTH-1:0] pin_in;

  logic     access;
  logic     wr_en;
  logic     rd_en;
  reg_sel_e reg_sel;

  assign access = apb.PSEL & apb.PENABLE;
  assign wr_en  = access & apb.PWRITE;
  assign rd_en  = access & ~apb.PWRITE;

  always_comb begin
    reg_sel = SEL_NONE;
    if (apb.PADDR == ADDR_W'(ADDR_DATA)) begin
      reg_sel = SEL_DATA;
    end else if (apb.PADDR == ADDR_W'(ADDR_DIR)) begin
      reg_sel = SEL_DIR;
    end
  end

  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    if (wr_en) begin
      case (reg_sel)
        SEL_DATA: data_d = apb.PWDATA;
        SEL_DIR:  dir_d  = apb.PWDATA;
        default:  ;
      endcase
    end
  end

  // DATA bits of input pins are kept so they reappear when the bit turns output.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      data_q <= '0;
      dir_q  <= '0;
    end else begin
      data_q <= data_d;
      dir_q  <= dir_d;
    end
  end

  // DATA reads return the pad level, so output bits echo the driven value.
  always_comb begin
    apb.PRDATA = '0;
    if (rd_en) begin
      case (reg_sel)
        SEL_DATA: apb.PRDATA = pin_in;
        SEL_DIR:  apb.PRDATA = dir_q;
        default:  apb.PRDATA = '0;
      endcase
    end
  end

  assign apb.PREADY = access;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
    gpio_pin_cell u_cell (
      .out_i (data_q[gi]),
      .dir_i (dir_q[gi]),
      .in_o  (pin_in[gi]),
      .pad   (pins[gi])
    );
  end

endmodule

// File: tb/tb_gpio.sv
// Scoreboard bench for gpio: expectations are queued when stimulus is applied
// and popped as the DUT produces bus responses or pad levels.
module tb_gpio;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 8;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] val;
  } exp_t;

  logic PCLK;
  logic PRESET;
  logic [WIDTH-1:0] ext_en;
  logic [WIDTH-1:0] ext_val;
  wire  [WIDTH-1:0] pins;

  int checks;
  int failures;
  exp_t sb_q[$];

  gpio_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  gpio #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .apb    (bus.slave),
    .pins   (pins)
  );

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ext
    assign pins[gi] = ext_en[gi] ? ext_val[gi] : 1'bz;
  end

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check_val(input string tag, input logic [WIDTH-1:0] got,
                           input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%02h expected=0x%02h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [WIDTH-1:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic observe(input logic [WIDTH-1:0] actual);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", WIDTH'(sb_q.size()), WIDTH'(1));
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, actual, e.val);
    end
  endtask

  task automatic bus_idle();
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
  endtask

  task automatic apb_write(input logic [ADDR_W-1:0] addr, input logic [WIDTH-1:0] data);
    @(negedge PCLK);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = addr;
    bus.PWDATA  = data;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    expect_val("wr_pready", 8'h01);
    #1 observe({7'd0, bus.PREADY});
    @(negedge PCLK);
    bus_idle();
    $display("WRITE addr=0x%02h data=0x%02h", addr, data);
  endtask

  task automatic apb_read(input string tag, input logic [ADDR_W-1:0] addr,
                          input logic [WIDTH-1:0] exp);
    @(negedge PCLK);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = addr;
    expect_val({tag, "_setup"}, 8'h00);
    #1 observe(bus.PRDATA);
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    expect_val(tag, exp);
    #1 observe(bus.PRDATA);
    $display("READ  addr=0x%02h data=0x%02h expected=0x%02h", addr, bus.PRDATA, exp);
    @(negedge PCLK);
    bus_idle();
  endtask

  task automatic check_pins(input string tag, input logic [WIDTH-1:0] exp);
    expect_val(tag, exp);
    #1 observe(pins);
    $display("PINS  %s value=0x%02h expected=0x%02h", tag, pins, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    checks   = 0;
    failures = 0;
    bus_idle();
    PRESET  = 1'b1;
    ext_en  = 8'hFF;
    ext_val = 8'h00;

    // Reset state: no bus activity, pads released.
    repeat (2) @(negedge PCLK);
    expect_val("rst_pready", 8'h00);
    #1 observe({7'd0, bus.PREADY});
    expect_val("rst_prdata", 8'h00);
    #1 observe(bus.PRDATA);
    check_pins("rst_pins", 8'h00);
    @(negedge PCLK);
    PRESET = 1'b0;
    apb_read("rst_dir", 8'h01, 8'h00);

    // Upper nibble output, lower nibble pulled low externally.
    ext_en  = 8'h0F;
    ext_val = 8'h00;
    apb_write(8'h01, 8'hF0);
    check_pins("dir_pins", 8'h00);
    apb_write(8'h00, 8'hE3);
    check_pins("data_pins", 8'hE0);
    apb_read("data_rd_low", 8'h00, 8'hE0);

    // External high on the input nibble.
    ext_val = 8'h0F;
    check_pins("ext_pins", 8'hEF);
    apb_read("ext_rd_data", 8'h00, 8'hEF);
    apb_read("ext_rd_dir", 8'h01, 8'hF0);

    // PSEL low must neither write nor respond.
    @(negedge PCLK);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b1;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = 8'h00;
    bus.PWDATA  = 8'h55;
    expect_val("gate_pready", 8'h00);
    #1 observe({7'd0, bus.PREADY});
    @(negedge PCLK);
    bus_idle();
    check_pins("gate_pins", 8'hEF);

    // Unmapped address.
    apb_write(8'h07, 8'hAA);
    apb_read("unmap_rd", 8'h07, 8'h00);
    apb_read("unmap_dir", 8'h01, 8'hF0);
    apb_read("unmap_data", 8'h00, 8'hEF);

    // Retained DATA bits appear when lower nibble turns output.
    ext_en  = 8'hF0;
    ext_val = 8'h00;
    apb_write(8'h01, 8'h0F);
    check_pins("retain_pins", 8'h03);
    apb_read("retain_rd", 8'h00, 8'h03);

    // Asynchronous reset between edges releases all pads at once.
    ext_en = 8'h00;
    apb_write(8'h00, 8'hFF);
    apb_write(8'h01, 8'hFF);
    check_pins("allout_pins", 8'hFF);
    @(posedge PCLK);
    #2;
    PRESET  = 1'b1;
    ext_en  = 8'hFF;
    ext_val = 8'h00;
    check_pins("async_rst_pins", 8'h00);
    @(negedge PCLK);
    PRESET = 1'b0;
    ext_en = 8'h00;
    apb_read("post_rst_dir", 8'h01, 8'h00);

    // Reset held across an access-phase write aborts it.
    @(negedge PCLK);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b1;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = 8'h00;
    bus.PWDATA  = 8'h5A;
    PRESET      = 1'b1;
    @(negedge PCLK);
    bus_idle();
    PRESET = 1'b0;
    apb_write(8'h01, 8'hFF);
    check_pins("abort_pins", 8'h00);

    check_val("sb_drained", WIDTH'(sb_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
